// File: rtl/weight_bram_streamer.sv
// weight_bram_streamer: streams one frequency of BRAM words through round/shift/saturate to AXI-Stream.
// Define WBS_SAT_FLAG_EN to enable the sticky sat_flag output.
module weight_bram_streamer #(
  parameter int IN_WIDTH    = 48,
  parameter int OUT_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int RD_INCREASE = 6,
  parameter int MIC_NUM     = 8,
  parameter int SOR_NUM     = 2,
  parameter int FREQ_NUM    = 257,
  parameter int LATENCY     = 3,
  parameter int SHIFT       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [ADDR_WIDTH-1:0]  bram_rd_addr,
  output logic                   bram_rd_en,
  input  logic [IN_WIDTH-1:0]    bram_rd_real,
  input  logic [IN_WIDTH-1:0]    bram_rd_imag,
  output logic [2*OUT_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic [8:0]             m_tuser,
  output logic                   busy,
  output logic                   done,
  output logic                   all_freq_finish,
  output logic                   sat_flag
);
  localparam int PER_FREQ = MIC_NUM * SOR_NUM;
  localparam int DEPTH = LATENCY + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int KW = $clog2(PER_FREQ + 1);
  localparam logic signed [IN_WIDTH:0] RND  = (IN_WIDTH+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_WIDTH:0] OMAX = ((IN_WIDTH+1)'(1) << (OUT_WIDTH - 1)) - (IN_WIDTH+1)'(1);
  localparam logic signed [IN_WIDTH:0] OMIN = -OMAX - (IN_WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  function automatic logic signed [IN_WIDTH:0] rnd_shift(input logic [IN_WIDTH-1:0] x);
    return ($signed({x[IN_WIDTH-1], x}) + RND) >>> SHIFT;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] sat_val(input logic [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH:0] s;
    s = rnd_shift(x);
    return s > OMAX ? OMAX[OUT_WIDTH-1:0] : s < OMIN ? OMIN[OUT_WIDTH-1:0] : s[OUT_WIDTH-1:0];
  endfunction

  state_t state_q, state_d;
  logic [8:0] freq_idx_q, freq_idx_d;
  logic [KW-1:0] k_q, k_d;
  logic [LATENCY-1:0] pipe_q, pipe_d, lpipe_q, lpipe_d;
  logic [2*OUT_WIDTH-1:0] dat_q [DEPTH];
  logic [2*OUT_WIDTH-1:0] dat_d [DEPTH];
  logic [DEPTH-1:0] last_q, last_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d, infl;
  logic done_q, done_d, fin_q, fin_d;
  logic issue, cap, pop, accept;

  // Reads in flight are counted against FIFO space so backpressure never drops data.
  always_comb begin
    infl = '0;
    for (int i = 0; i < LATENCY; i++) infl = infl + CW'(pipe_q[i]);
  end

  assign m_tvalid = cnt_q != '0;
  assign pop = m_tvalid & m_tready;
  assign cap = pipe_q[LATENCY-1];
  assign accept = start && state_q == IDLE && !done_q;
  assign issue = state_q == RUN && k_q != KW'(PER_FREQ) && int'(infl) + int'(cnt_q) < DEPTH;
  assign bram_rd_en = issue;
  assign bram_rd_addr = issue ? ADDR_WIDTH'((int'(freq_idx_q) * PER_FREQ + int'(k_q)) * RD_INCREASE) : '0;
  assign m_tdata = dat_q[rp_q];
  assign m_tlast = m_tvalid && last_q[rp_q];
  assign m_tuser = freq_idx_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign all_freq_finish = fin_q;

  always_comb begin
    state_d = state_q;
    freq_idx_d = freq_idx_q;
    k_d = k_q;
    done_d = 1'b0;
    fin_d = fin_q;
    pipe_d = LATENCY'({pipe_q, issue});
    lpipe_d = LATENCY'({lpipe_q, issue && k_q == KW'(PER_FREQ - 1)});
    dat_d = dat_q;
    last_d = last_q;
    wp_d = wp_q;
    rp_d = rp_q;
    cnt_d = cnt_q + CW'(cap) - CW'(pop);
    if (cap) begin
      dat_d[wp_q] = {sat_val(bram_rd_imag), sat_val(bram_rd_real)};
      last_d[wp_q] = lpipe_q[LATENCY-1];
      wp_d = wp_q == PW'(DEPTH - 1) ? '0 : wp_q + PW'(1);
    end
    if (pop) rp_d = rp_q == PW'(DEPTH - 1) ? '0 : rp_q + PW'(1);
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = RUN;
        k_d = '0;
        fin_d = 1'b0;
      end
      RUN: begin
        if (issue) k_d = k_q + KW'(1);
        if (issue && k_q == KW'(PER_FREQ - 1)) state_d = DRAIN;
      end
      DRAIN: if (pop && m_tlast) begin
        state_d = IDLE;
        done_d = 1'b1;
        freq_idx_d = freq_idx_q == 9'(FREQ_NUM - 1) ? '0 : freq_idx_q + 9'(1);
        fin_d = freq_idx_q == 9'(FREQ_NUM - 1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      freq_idx_q <= '0;
      k_q <= '0;
      pipe_q <= '0;
      lpipe_q <= '0;
      dat_q <= '{default: '0};
      last_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_idx_q <= freq_idx_d;
      k_q <= k_d;
      pipe_q <= pipe_d;
      lpipe_q <= lpipe_d;
      dat_q <= dat_d;
      last_q <= last_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      fin_q <= fin_d;
    end
  end

`ifdef WBS_SAT_FLAG_EN
  function automatic logic is_sat(input logic [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH:0] s;
    s = rnd_shift(x);
    return s > OMAX || s < OMIN;
  endfunction

  logic [DEPTH-1:0] fsat_q, fsat_d;
  logic sat_q, sat_d;

  always_comb begin
    fsat_d = fsat_q;
    if (cap) fsat_d[wp_q] = is_sat(bram_rd_real) || is_sat(bram_rd_imag);
    sat_d = sat_q | (pop & fsat_q[rp_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsat_q <= '0;
      sat_q <= 1'b0;
    end else begin
      fsat_q <= fsat_d;
      sat_q <= sat_d;
    end
  end

  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif
endmodule

// File: tb/tb_weight_bram_streamer.sv
// tb_weight_bram_streamer: scoreboard bench with a BRAM model and an arithmetic reference model.
module tb_weight_bram_streamer;
  localparam int IW = 48, OW = 16, AW = 32, SH = 16, FN = 257, PF = 16, RI = 6;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, m_tready = 1'b0;
  logic [AW-1:0] bram_rd_addr;
  logic bram_rd_en;
  logic [IW-1:0] bram_rd_real = '0, bram_rd_imag = '0;
  logic [2*OW-1:0] m_tdata;
  logic m_tvalid, m_tlast, busy, done, all_freq_finish, sat_flag;
  logic [8:0] m_tuser;

  weight_bram_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bram_rd_addr(bram_rd_addr), .bram_rd_en(bram_rd_en),
    .bram_rd_real(bram_rd_real), .bram_rd_imag(bram_rd_imag),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .busy(busy), .done(done),
    .all_freq_finish(all_freq_finish), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic last;
    logic [8:0] user;
    logic sat;
  } exp_t;

  exp_t exp_q[$];
  int addr_q[$];
  logic [IW-1:0] mem_r[int];
  logic [IW-1:0] mem_i[int];
  logic [IW-1:0] p1r, p1i, p2r, p2i;
  int n_tests = 0, n_fail = 0;
  bit active = 0, exp_sat = 0;
  int model_freq = 0, fill_mode = 0, rdy_mode = 0, hs_cnt = 0;

  // BRAM with three cycles from address to data
  always @(posedge clk) begin
    p1r <= bram_rd_en && mem_r.exists(int'(bram_rd_addr)) ? mem_r[int'(bram_rd_addr)] : '0;
    p1i <= bram_rd_en && mem_i.exists(int'(bram_rd_addr)) ? mem_i[int'(bram_rd_addr)] : '0;
    p2r <= p1r;
    p2i <= p1i;
    bram_rd_real <= p2r;
    bram_rd_imag <= p2i;
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail1(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got unexpected or missing event, expected none", name);
  endtask

  // Round half up, floor-shift, clamp: returns {saturated, value}
  function automatic logic [16:0] ref_q(input logic [IW-1:0] v);
    longint x, y, hi, lo;
    x = longint'($signed(v));
    y = (x + (longint'(1) << (SH - 1))) >>> SH;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -hi - 1;
    if (y > hi) return {1'b1, hi[15:0]};
    if (y < lo) return {1'b1, lo[15:0]};
    return {1'b0, y[15:0]};
  endfunction

  function automatic logic [IW-1:0] rnd_word();
    logic [31:0] r;
    r = $urandom;
    return {{17{r[30]}}, r[30:0]};
  endfunction

  task automatic accept_freq();
    logic [IW-1:0] r, i;
    logic [16:0] qr, qi;
    int a;
    exp_t e;
    active = 1;
    for (int k = 0; k < PF; k++) begin
      a = (model_freq * PF + k) * RI;
      r = rnd_word();
      i = rnd_word();
      if (fill_mode == 1) r = IW'(k) << 16;
      if (fill_mode == 2 && k == 0) begin
        r = 48'h0000_0000_8000;
        i = 48'h7FFF_FFFF_FFFF;
      end
      if (fill_mode == 2 && k == 1) r = 48'h8000_0000_0000;
      mem_r[a] = r;
      mem_i[a] = i;
      addr_q.push_back(a);
      qr = ref_q(r);
      qi = ref_q(i);
      e.data = {qi[15:0], qr[15:0]};
      e.last = k == PF - 1;
      e.user = 9'(model_freq);
      e.sat = qr[16] | qi[16];
      exp_q.push_back(e);
    end
    model_freq = (model_freq + 1) % FN;
  endtask

  task automatic start_burst(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      if (!active) accept_freq();
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || active) && c < max) begin
      @(negedge clk);
      c++;
    end
    if (c >= max) fail1("timeout_idle");
    chk("addr_q_drained", addr_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? !m_tready :
                 rdy_mode == 2 ? ($urandom_range(0, 3) != 0) : 1'b0;
    end
  end

  exp_t me;
  bit stall_p = 0, last_p = 0;
  logic [42:0] hold_p;
  logic [8:0] last_user_p;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_p = 0;
      last_p = 0;
    end else begin
      if (bram_rd_en) begin
        if (addr_q.size() == 0) fail1("extra_read");
        else chk("rd_addr", bram_rd_addr, addr_q.pop_front());
      end
      if (stall_p) chk("stall_hold", {m_tvalid, m_tlast, m_tuser, m_tdata}, hold_p);
      if (done || last_p) chk("done", done, last_p);
      if (done) begin
        chk("all_freq_finish", all_freq_finish, last_user_p == 9'(FN - 1));
        active = 0;
      end
      if (m_tvalid && m_tready) begin
`ifdef WBS_SAT_FLAG_EN
        chk("sat_flag", sat_flag, exp_sat);
`else
        chk("sat_flag", sat_flag, 0);
`endif
        if (exp_q.size() == 0) fail1("extra_word");
        else begin
          me = exp_q.pop_front();
          chk("m_tdata", m_tdata, me.data);
          chk("m_tlast", m_tlast, me.last);
          chk("m_tuser", m_tuser, me.user);
          exp_sat = exp_sat | me.sat;
        end
        hs_cnt = m_tlast ? 0 : hs_cnt + 1;
        last_p = m_tlast;
        last_user_p = m_tuser;
      end else last_p = 0;
      stall_p = m_tvalid && !m_tready;
      hold_p = {m_tvalid, m_tlast, m_tuser, m_tdata};
    end
  end

  initial begin
    int c, guard;
    #1 rst_n = 1'b0;
    #1 chk("reset_outputs", {m_tvalid, m_tdata, m_tlast, m_tuser, busy, done, all_freq_finish,
                             sat_flag, bram_rd_en, bram_rd_addr}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fill_mode = 1;
    start_burst(1);
    wait_idle(500);
    fill_mode = 0;
    rdy_mode = 2;
    repeat (4) begin
      start_burst(1);
      wait_idle(500);
    end
    rdy_mode = 1;
    start_burst(1);
    wait_idle(500);
    rdy_mode = 0;
    fill_mode = 2;
    start_burst(1);
    wait_idle(500);
`ifdef WBS_SAT_FLAG_EN
    chk("sat_flag_after_sat", sat_flag, 1);
`else
    chk("sat_flag_after_sat", sat_flag, 0);
`endif
    fill_mode = 0;
    rdy_mode = 2;
    start_burst(120);
    wait_idle(1000);
    rdy_mode = 0;
    guard = 0;
    while (model_freq != 0 && guard < 300) begin
      start_burst(1);
      wait_idle(500);
      guard++;
    end
    chk("all_fin_level", all_freq_finish, 1);
    start_burst(1);
    chk("all_fin_clear", all_freq_finish, 0);
    wait_idle(500);
    start_burst(1);
    c = 0;
    while (hs_cnt < 7 && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (c >= 500) fail1("wait_word7");
    rdy_mode = 3;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrun_reset_outputs", {m_tvalid, m_tdata, m_tlast, m_tuser, busy, done, all_freq_finish,
                                    sat_flag, bram_rd_en, bram_rd_addr}, 0);
    exp_q.delete();
    addr_q.delete();
    active = 0;
    model_freq = 0;
    exp_sat = 0;
    hs_cnt = 0;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_mode = 1;
    start_burst(1);
    wait_idle(500);
    chk("idle_after", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
